// File: rtl/ahb_bridge_length_decoder_pkg.sv
// Shared types and the length-to-HSIZE mapping for the bridge-side length decoder.
// Inverse of the master-side HSIZE-to-byte-count encoder.
package ahb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam logic [2:0] HSIZE_8   = 3'b000;
  localparam logic [2:0] HSIZE_16  = 3'b001;
  localparam logic [2:0] HSIZE_32  = 3'b010;
  localparam logic [2:0] HSIZE_64  = 3'b011;
  localparam logic [2:0] HSIZE_128 = 3'b100;
  localparam logic [2:0] HSIZE_256 = 3'b101;

  typedef struct packed {
    logic       legal;
    logic [2:0] hsize;
  } size_dec_t;

  // Only exact powers of two up to max_bytes are legal; illegal lengths report HSIZE_8.
  function automatic size_dec_t len_to_hsize(input logic [5:0] len,
                                             input int unsigned max_bytes);
    size_dec_t r;
    r.legal = 1'b1;
    r.hsize = HSIZE_8;
    case (len)
      6'd1:    r.hsize = HSIZE_8;
      6'd2:    r.hsize = HSIZE_16;
      6'd4:    r.hsize = HSIZE_32;
      6'd8:    r.hsize = HSIZE_64;
      6'd16:   r.hsize = HSIZE_128;
      6'd32:   r.hsize = HSIZE_256;
      default: r.legal = 1'b0;
    endcase
    if ({26'd0, len} > max_bytes) r.legal = 1'b0;
    if (!r.legal) r.hsize = HSIZE_8;
    return r;
  endfunction

endpackage

// File: rtl/ahb_bridge_length_decoder_if.sv
// Bus bundle between the bridge byte datapath (master) and the length decoder (slave).
// Every channel transfers on a cycle where valid & ready are both high at the rising edge.
interface ahb_bridge_length_decoder_if #(
  parameter int unsigned MAX_BYTES = 32
) ();
  localparam int unsigned DATA_W = 8 * MAX_BYTES;

  logic              LEN_VALID;
  logic [5:0]        SIGNAL_LENGTH;
  logic              LEN_READY;
  logic              BYTE_VALID;
  logic [7:0]        BYTE_DATA;
  logic              BYTE_READY;
  logic              WORD_VALID;
  logic              WORD_READY;
  logic [DATA_W-1:0] WORD_DATA;
  logic [2:0]        HSIZES;
  logic              SIZE_ERR;

  modport master (
    output LEN_VALID, SIGNAL_LENGTH, BYTE_VALID, BYTE_DATA, WORD_READY,
    input  LEN_READY, BYTE_READY, WORD_VALID, WORD_DATA, HSIZES, SIZE_ERR
  );

  modport slave (
    input  LEN_VALID, SIGNAL_LENGTH, BYTE_VALID, BYTE_DATA, WORD_READY,
    output LEN_READY, BYTE_READY, WORD_VALID, WORD_DATA, HSIZES, SIZE_ERR
  );
endinterface

// File: rtl/ahb_bridge_length_decoder_size_decoder.sv
// Combinational byte-count to HSIZE decoder, bounded by MAX_BYTES.
module bridge_size_decoder
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 32
) (
  input  logic [5:0] SIGNAL_LENGTH,
  output logic       LEGAL,
  output logic [2:0] HSIZES
);
  size_dec_t dec;

  always_comb begin
    dec    = len_to_hsize(SIGNAL_LENGTH, MAX_BYTES);
    LEGAL  = dec.legal;
    HSIZES = dec.hsize;
  end
endmodule

// File: rtl/ahb_bridge_length_decoder.sv
// Takes a byte count and a serial LSB-first byte stream, recovers HSIZE and
// packs the bytes into one word handed downstream on a valid/ready channel.
module ahb_bridge_length_decoder
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  ahb_bridge_length_decoder_if.slave  bus,
  output state_t                      state_dbg
);
  localparam int unsigned DATA_W = 8 * MAX_BYTES;

  state_t            state;
  logic [5:0]        cnt;
  logic [5:0]        len;
  logic              len_ready;
  logic              byte_ready;
  logic              word_valid;
  logic [DATA_W-1:0] word_data;
  logic [2:0]        hsizes;
  logic              size_err;

  logic              dec_legal;
  logic [2:0]        dec_hsize;
  logic              len_hs;
  logic              byte_hs;
  logic              word_hs;
  logic              last_byte;
  logic [MAX_BYTES-1:0] lane_we;

  bridge_size_decoder #(.MAX_BYTES(MAX_BYTES)) u_size_dec (
    .SIGNAL_LENGTH (bus.SIGNAL_LENGTH),
    .LEGAL         (dec_legal),
    .HSIZES        (dec_hsize)
  );

  // Ready flags are registered per state, so handshakes only fire in the owning state.
  always_comb begin
    len_hs    = len_ready & bus.LEN_VALID;
    byte_hs   = byte_ready & bus.BYTE_VALID;
    word_hs   = word_valid & bus.WORD_READY;
    last_byte = (cnt == (len - 6'd1));
    lane_we   = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      lane_we[i] = byte_hs && (cnt == 6'(i));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      len_ready  <= 1'b0;
      byte_ready <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      hsizes     <= '0;
      size_err   <= 1'b0;
    end else begin
      size_err <= 1'b0;
      case (state)
        IDLE: begin
          len_ready <= 1'b1;
          if (len_hs) begin
            if (dec_legal) begin
              len        <= bus.SIGNAL_LENGTH;
              hsizes     <= dec_hsize;
              word_data  <= '0;
              cnt        <= '0;
              len_ready  <= 1'b0;
              byte_ready <= 1'b1;
              state      <= COLLECT;
            end else begin
              size_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (lane_we[i]) word_data[8*i +: 8] <= bus.BYTE_DATA;
          end
          if (byte_hs) begin
            cnt <= cnt + 6'd1;
            if (last_byte) begin
              byte_ready <= 1'b0;
              word_valid <= 1'b1;
              state      <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (word_hs) begin
            word_valid <= 1'b0;
            len_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          len_ready  <= 1'b0;
          byte_ready <= 1'b0;
          word_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.LEN_READY  = len_ready;
  assign bus.BYTE_READY = byte_ready;
  assign bus.WORD_VALID = word_valid;
  assign bus.WORD_DATA  = word_data;
  assign bus.HSIZES     = hsizes;
  assign bus.SIZE_ERR   = size_err;
  assign state_dbg      = state;

endmodule

// File: tb/tb_ahb_bridge_length_decoder.sv
// Directed bench for ahb_bridge_length_decoder: reset, packing, waits, illegal
// lengths, mid-transfer reset and back-to-back length acceptance.
module tb_ahb_bridge_length_decoder;
  import ahb_bridge_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     checks;
  int     errors;
  logic [255:0] exp32;
  logic [5:0]   bad_len [3];

  ahb_bridge_length_decoder_if #(.MAX_BYTES(32)) bus ();

  ahb_bridge_length_decoder #(.MAX_BYTES(32)) dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic send_len(input logic [5:0] l);
    logic hs;
    hs = 1'b0;
    bus.LEN_VALID     = 1'b1;
    bus.SIGNAL_LENGTH = l;
    for (int n = 0; n < 20; n++) begin
      if (bus.LEN_READY) begin
        tick();
        hs = 1'b1;
        break;
      end
      tick();
    end
    bus.LEN_VALID = 1'b0;
    chk("len_handshake", {255'd0, hs}, 256'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic hs;
    hs = 1'b0;
    bus.BYTE_VALID = 1'b1;
    bus.BYTE_DATA  = b;
    for (int n = 0; n < 20; n++) begin
      if (bus.BYTE_READY) begin
        tick();
        hs = 1'b1;
        break;
      end
      tick();
    end
    bus.BYTE_VALID = 1'b0;
    chk("byte_handshake", {255'd0, hs}, 256'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_len_ready"},  {255'd0, bus.LEN_READY},  256'd0);
    chk({tag, "_byte_ready"}, {255'd0, bus.BYTE_READY}, 256'd0);
    chk({tag, "_word_valid"}, {255'd0, bus.WORD_VALID}, 256'd0);
    chk({tag, "_word_data"},  bus.WORD_DATA,            256'd0);
    chk({tag, "_hsizes"},     {253'd0, bus.HSIZES},     256'd0);
    chk({tag, "_size_err"},   {255'd0, bus.SIZE_ERR},   256'd0);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus.LEN_VALID     = 1'b0;
    bus.SIGNAL_LENGTH = '0;
    bus.BYTE_VALID    = 1'b0;
    bus.BYTE_DATA     = '0;
    bus.WORD_READY    = 1'b0;

    // 1. reset
    @(negedge clk);
    chk_all_zero("rst");
    chk("rst_state", {254'd0, state_dbg}, {254'd0, IDLE});
    tick();
    rst_n = 1'b1;
    chk("rel_len_ready_before_edge", {255'd0, bus.LEN_READY}, 256'd0);
    tick();
    chk("rel_len_ready_first_edge", {255'd0, bus.LEN_READY}, 256'd1);

    // 2. length 4, WORD_READY held high
    bus.WORD_READY = 1'b1;
    send_len(6'd4);
    chk("t2_state_collect", {254'd0, state_dbg}, {254'd0, COLLECT});
    chk("t2_byte_ready", {255'd0, bus.BYTE_READY}, 256'd1);
    chk("t2_len_ready", {255'd0, bus.LEN_READY}, 256'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("t2_no_early_valid", {255'd0, bus.WORD_VALID}, 256'd0);
    send_byte(8'h44);
    chk("t2_word_valid", {255'd0, bus.WORD_VALID}, 256'd1);
    chk("t2_word_data", bus.WORD_DATA, 256'h44332211);
    chk("t2_hsizes", {253'd0, bus.HSIZES}, 256'd2);
    tick();
    chk("t2_valid_drop", {255'd0, bus.WORD_VALID}, 256'd0);
    chk("t2_back_idle", {254'd0, state_dbg}, {254'd0, IDLE});
    chk("t2_len_ready_again", {255'd0, bus.LEN_READY}, 256'd1);

    // 3. length 32, gapped bytes, downstream stalls 5 cycles with surplus bytes offered
    bus.WORD_READY = 1'b0;
    exp32 = '0;
    send_len(6'd32);
    for (int i = 0; i < 32; i++) begin
      exp32[8*i +: 8] = 8'(i * 7 + 3);
      send_byte(8'(i * 7 + 3));
      if (i < 31) tick();
    end
    bus.BYTE_VALID = 1'b1;
    bus.BYTE_DATA  = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid_hold", {255'd0, bus.WORD_VALID}, 256'd1);
      chk("t3_data_hold", bus.WORD_DATA, exp32);
      chk("t3_no_byte_ready", {255'd0, bus.BYTE_READY}, 256'd0);
      tick();
    end
    chk("t3_hsizes", {253'd0, bus.HSIZES}, 256'd5);
    bus.WORD_READY = 1'b1;
    tick();
    bus.WORD_READY = 1'b0;
    bus.BYTE_VALID = 1'b0;
    chk("t3_valid_drop", {255'd0, bus.WORD_VALID}, 256'd0);
    chk("t3_idle", {254'd0, state_dbg}, {254'd0, IDLE});

    // 4. illegal lengths, then a 1-byte transfer
    bad_len[0] = 6'd0;
    bad_len[1] = 6'd3;
    bad_len[2] = 6'd48;
    for (int j = 0; j < 3; j++) begin
      send_len(bad_len[j]);
      chk("t4_size_err", {255'd0, bus.SIZE_ERR}, 256'd1);
      chk("t4_stay_idle", {254'd0, state_dbg}, {254'd0, IDLE});
      chk("t4_no_byte_ready", {255'd0, bus.BYTE_READY}, 256'd0);
      chk("t4_no_word_valid", {255'd0, bus.WORD_VALID}, 256'd0);
      tick();
      chk("t4_err_pulse_end", {255'd0, bus.SIZE_ERR}, 256'd0);
      chk("t4_no_byte_ready2", {255'd0, bus.BYTE_READY}, 256'd0);
    end
    chk("t4_hsizes_kept", {253'd0, bus.HSIZES}, 256'd5);
    chk("t4_data_kept", bus.WORD_DATA, exp32);
    send_len(6'd1);
    chk("t4_len1_hsizes", {253'd0, bus.HSIZES}, 256'd0);
    chk("t4_len1_cleared", bus.WORD_DATA, 256'd0);
    send_byte(8'h5A);
    chk("t4_len1_valid", {255'd0, bus.WORD_VALID}, 256'd1);
    chk("t4_len1_data", bus.WORD_DATA, 256'h5A);
    bus.WORD_READY = 1'b1;
    tick();
    bus.WORD_READY = 1'b0;

    // 5. reset in the middle of an 8-byte transfer
    send_len(6'd8);
    chk("t5_hsizes", {253'd0, bus.HSIZES}, 256'd3);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    chk("t5_rst_state", {254'd0, state_dbg}, {254'd0, IDLE});
    #2;
    rst_n = 1'b1;
    tick();
    send_len(6'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("t5_valid", {255'd0, bus.WORD_VALID}, 256'd1);
    chk("t5_data", bus.WORD_DATA, 256'hBBAA);
    chk("t5_hsizes2", {253'd0, bus.HSIZES}, 256'd1);
    bus.WORD_READY = 1'b1;
    tick();
    bus.WORD_READY = 1'b0;

    // 6. LEN_VALID held through OUTPUT: accepted one cycle after the word handshake
    send_len(6'd1);
    send_byte(8'h77);
    bus.LEN_VALID     = 1'b1;
    bus.SIGNAL_LENGTH = 6'd2;
    tick();
    chk("t6_len_ignored", {254'd0, state_dbg}, {254'd0, OUTPUT});
    chk("t6_len_ready_low", {255'd0, bus.LEN_READY}, 256'd0);
    tick();
    chk("t6_still_output", {254'd0, state_dbg}, {254'd0, OUTPUT});
    bus.WORD_READY = 1'b1;
    tick();
    bus.WORD_READY = 1'b0;
    chk("t6_idle_at_t1", {254'd0, state_dbg}, {254'd0, IDLE});
    chk("t6_len_ready_t1", {255'd0, bus.LEN_READY}, 256'd1);
    chk("t6_valid_drop", {255'd0, bus.WORD_VALID}, 256'd0);
    tick();
    bus.LEN_VALID = 1'b0;
    chk("t6_accepted_t1", {254'd0, state_dbg}, {254'd0, COLLECT});
    chk("t6_byte_ready", {255'd0, bus.BYTE_READY}, 256'd1);
    chk("t6_hsizes", {253'd0, bus.HSIZES}, 256'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t6_data", bus.WORD_DATA, 256'h0201);
    bus.WORD_READY = 1'b1;
    tick();
    bus.WORD_READY = 1'b0;
    chk("t6_final_idle", {254'd0, state_dbg}, {254'd0, IDLE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
